// File: rtl/trigger_window_gate.sv
// Trigger-window gate: forwards the delayed payload while any lane of the undelayed
// stream is below threshold, plus a programmable tail of post-acquisition beats.
module trigger_window_gate #(
  parameter int WIDTH          = 128,
  parameter int SAMPLE_WIDTH   = 16,
  parameter int POST_CNT_WIDTH = 5,
  parameter int MAX_FRAME_LEN  = 256
) (
  input  logic                             CLK,
  input  logic                             RESETN,
  input  logic signed [SAMPLE_WIDTH-1:0]   THRESHOLD,
  input  logic        [POST_CNT_WIDTH-1:0] POST_ACQ,
  input  logic                             iVALID,
  input  logic        [WIDTH-1:0]          TRIG_DIN,
  input  logic        [WIDTH-1:0]          DELAYED_DIN,
  output logic        [WIDTH-1:0]          DOUT,
  output logic                             oVALID,
  output logic                             oLAST,
  output logic        [15:0]               TRIG_CNT
);

  localparam int LANES = WIDTH / SAMPLE_WIDTH;
  localparam int FCW   = $clog2(MAX_FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACQ, POST} state_t;

  state_t                          state_reg;
  logic signed [SAMPLE_WIDTH-1:0]  thr_reg;
  logic        [POST_CNT_WIDTH-1:0] post_acq_reg;
  logic        [POST_CNT_WIDTH-1:0] post_cnt_reg;
  logic        [FCW-1:0]           frame_cnt_reg;
  logic        [WIDTH-1:0]         dout_reg;
  logic                            ovalid_reg;
  logic                            olast_reg;
  logic        [15:0]              trig_cnt_reg;

  logic [LANES-1:0] lt_live;
  logic [LANES-1:0] lt_lat;
  logic             hit_live;
  logic             hit_lat;
  logic [FCW-1:0]   frame_next;
  logic             frame_full;

  // IDLE compares against the live threshold, an open frame against the latched one
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [SAMPLE_WIDTH-1:0] sample;
    assign sample      = TRIG_DIN[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign lt_live[gi] = sample < THRESHOLD;
    assign lt_lat[gi]  = sample < thr_reg;
  end

  assign hit_live   = iVALID & (|lt_live);
  assign hit_lat    = iVALID & (|lt_lat);
  assign frame_next = frame_cnt_reg + FCW'(1);
  assign frame_full = (frame_next == FCW'(MAX_FRAME_LEN));

  // post_cnt_reg counts trailing non-hit beats already gated in the current tail
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg     <= IDLE;
      thr_reg       <= '0;
      post_acq_reg  <= '0;
      post_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
      dout_reg      <= '0;
      ovalid_reg    <= 1'b0;
      olast_reg     <= 1'b0;
      trig_cnt_reg  <= '0;
    end else begin
      ovalid_reg <= 1'b0;
      olast_reg  <= 1'b0;
      if (iVALID) begin
        unique case (state_reg)
          IDLE: begin
            thr_reg      <= THRESHOLD;
            post_acq_reg <= POST_ACQ;
            if (hit_live) begin
              state_reg     <= ACQ;
              dout_reg      <= DELAYED_DIN;
              ovalid_reg    <= 1'b1;
              frame_cnt_reg <= FCW'(1);
              post_cnt_reg  <= '0;
              if (trig_cnt_reg != 16'hFFFF)
                trig_cnt_reg <= trig_cnt_reg + 16'd1;
            end
          end
          ACQ, POST: begin
            dout_reg      <= DELAYED_DIN;
            ovalid_reg    <= 1'b1;
            frame_cnt_reg <= frame_next;
            if (frame_full) begin
              state_reg     <= IDLE;
              olast_reg     <= 1'b1;
              post_cnt_reg  <= '0;
              frame_cnt_reg <= '0;
            end else if (hit_lat) begin
              state_reg    <= ACQ;
              post_cnt_reg <= '0;
            end else if ((state_reg == ACQ && post_acq_reg == '0) ||
                         (state_reg == POST && post_cnt_reg == post_acq_reg)) begin
              state_reg     <= IDLE;
              olast_reg     <= 1'b1;
              post_cnt_reg  <= '0;
              frame_cnt_reg <= '0;
            end else if (state_reg == ACQ) begin
              state_reg    <= POST;
              post_cnt_reg <= POST_CNT_WIDTH'(1);
            end else begin
              post_cnt_reg <= post_cnt_reg + POST_CNT_WIDTH'(1);
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign DOUT     = dout_reg;
  assign oVALID   = ovalid_reg;
  assign oLAST    = olast_reg;
  assign TRIG_CNT = trig_cnt_reg;

endmodule

// File: tb/tb_trigger_window_gate.sv
// Randomized and directed bench for trigger_window_gate against a frame-level model.
module tb_trigger_window_gate;

  localparam int W     = 128;
  localparam int SW    = 16;
  localparam int PW    = 5;
  localparam int MAXF  = 8;
  localparam int LANES = W / SW;

  logic                 CLK = 1'b0;
  logic                 RESETN = 1'b0;
  logic signed [SW-1:0] THRESHOLD;
  logic        [PW-1:0] POST_ACQ;
  logic                 iVALID;
  logic        [W-1:0]  TRIG_DIN;
  logic        [W-1:0]  DELAYED_DIN;
  logic        [W-1:0]  DOUT;
  logic                 oVALID;
  logic                 oLAST;
  logic        [15:0]   TRIG_CNT;

  trigger_window_gate #(
    .WIDTH(W), .SAMPLE_WIDTH(SW), .POST_CNT_WIDTH(PW), .MAX_FRAME_LEN(MAXF)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .THRESHOLD(THRESHOLD), .POST_ACQ(POST_ACQ),
    .iVALID(iVALID), .TRIG_DIN(TRIG_DIN), .DELAYED_DIN(DELAYED_DIN),
    .DOUT(DOUT), .oVALID(oVALID), .oLAST(oLAST), .TRIG_CNT(TRIG_CNT)
  );

  always #5 CLK = ~CLK;

  int tests_run    = 0;
  int tests_failed = 0;

  // Frame-level model: a frame is open while beats remain in its window
  bit                   m_active;
  int                   m_len;
  int                   m_remain;
  logic signed [SW-1:0] m_thr;
  int                   m_pa;
  logic        [15:0]   m_trig;
  bit                   m_valid;
  bit                   m_last;
  logic        [W-1:0]  m_dout;

  int n_beats;
  int n_lasts;

  function automatic bit is_hit(input logic [W-1:0] d, input logic signed [SW-1:0] t);
    for (int i = 0; i < LANES; i++)
      if ($signed(d[i*SW +: SW]) < t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] make_beat(input int lane, input int val);
    logic [W-1:0] b;
    for (int i = 0; i < LANES; i++)
      b[i*SW +: SW] = (i == lane) ? SW'(val) : SW'($urandom_range(0, 300));
    return b;
  endfunction

  function automatic logic [W-1:0] rand_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_active = 0; m_len = 0; m_remain = 0; m_thr = '0; m_pa = 0;
    m_trig = '0; m_valid = 0; m_last = 0; m_dout = '0;
    n_beats = 0; n_lasts = 0;
  endtask

  task automatic apply_reset();
    RESETN = 1'b0;
    iVALID = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    RESETN = 1'b1;
  endtask

  // Drive one cycle and advance the model; outputs are sampled 1 time unit after the edge
  task automatic step(input bit v, input logic [W-1:0] trig, input logic [W-1:0] pay);
    bit h;
    iVALID = v; TRIG_DIN = trig; DELAYED_DIN = pay;
    m_valid = 0; m_last = 0;
    if (v) begin
      if (!m_active) begin
        m_thr = THRESHOLD;
        m_pa  = int'(POST_ACQ);
        if (is_hit(trig, THRESHOLD)) begin
          m_active = 1; m_len = 1; m_remain = m_pa + 1;
          if (m_trig != 16'hFFFF) m_trig = m_trig + 16'd1;
          m_valid = 1; m_dout = pay;
        end
      end else begin
        h = is_hit(trig, m_thr);
        m_valid = 1; m_dout = pay; m_len++;
        if (h) m_remain = m_pa + 1;
        else   m_remain--;
        if (m_len == MAXF || (!h && m_remain == 0)) begin
          m_last = 1; m_active = 0;
        end
      end
    end
    @(posedge CLK); #1;
    if (oVALID === 1'b1) n_beats++;
    if (oLAST === 1'b1)  n_lasts++;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({oVALID, oLAST, TRIG_CNT, DOUT} !== {1'b0, 1'b0, 16'h0, {W{1'b0}}}) begin
      tests_failed++;
      $display("FAIL reset_state got v=%b l=%b cnt=%0d dout=%h required all zero",
               oVALID, oLAST, TRIG_CNT, DOUT);
    end
    RESETN = 1'b1;
    step(1'b1, make_beat(-1, 0), rand_payload());
    tests_run++;
    if (oVALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_nohit got oVALID=%b required 0", oVALID);
    end
  endtask

  task automatic test_single_hit();
    logic [W-1:0] pay;
    apply_reset();
    THRESHOLD = -16'sd100; POST_ACQ = 5'd2;
    pay = rand_payload();
    step(1'b1, make_beat(3, -200), pay);
    tests_run++;
    if (oVALID !== 1'b1 || DOUT !== pay) begin
      tests_failed++;
      $display("FAIL single_latency got v=%b dout=%h required v=1 dout=%h", oVALID, DOUT, pay);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, make_beat(-1, 0), rand_payload());
      tests_run++;
      if ({oVALID, oLAST, TRIG_CNT, DOUT} !== {m_valid, m_last, m_trig, m_dout}) begin
        tests_failed++;
        $display("FAIL single_cycle%0d got v=%b l=%b cnt=%0d required v=%b l=%b cnt=%0d",
                 i, oVALID, oLAST, TRIG_CNT, m_valid, m_last, m_trig);
      end
    end
    tests_run++;
    if (n_beats != 4 || n_lasts != 1 || TRIG_CNT !== 16'd1) begin
      tests_failed++;
      $display("FAIL single_totals got beats=%0d lasts=%0d cnt=%0d required 4 1 1",
               n_beats, n_lasts, TRIG_CNT);
    end
  endtask

  task automatic test_retrigger();
    apply_reset();
    THRESHOLD = -16'sd100; POST_ACQ = 5'd3;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, (i == 0 || i == 2) ? make_beat(i, -150) : make_beat(-1, 0), rand_payload());
      tests_run++;
      if ({oVALID, oLAST, TRIG_CNT, DOUT} !== {m_valid, m_last, m_trig, m_dout}) begin
        tests_failed++;
        $display("FAIL retrig_cycle%0d got v=%b l=%b cnt=%0d required v=%b l=%b cnt=%0d",
                 i, oVALID, oLAST, TRIG_CNT, m_valid, m_last, m_trig);
      end
    end
    tests_run++;
    if (n_beats != 7 || n_lasts != 1 || TRIG_CNT !== 16'd1) begin
      tests_failed++;
      $display("FAIL retrig_totals got beats=%0d lasts=%0d cnt=%0d required 7 1 1",
               n_beats, n_lasts, TRIG_CNT);
    end
  endtask

  task automatic test_max_frame();
    apply_reset();
    THRESHOLD = -16'sd100; POST_ACQ = 5'd1;
    for (int i = 0; i < 26; i++) begin
      step(1'b1, (i < 20) ? make_beat(i % LANES, -120) : make_beat(-1, 0), rand_payload());
      tests_run++;
      if ({oVALID, oLAST, TRIG_CNT, DOUT} !== {m_valid, m_last, m_trig, m_dout}) begin
        tests_failed++;
        $display("FAIL maxframe_cycle%0d got v=%b l=%b cnt=%0d required v=%b l=%b cnt=%0d",
                 i, oVALID, oLAST, TRIG_CNT, m_valid, m_last, m_trig);
      end
      if (i == 7 || i == 15 || i == 21) begin
        tests_run++;
        if (oLAST !== 1'b1) begin
          tests_failed++;
          $display("FAIL maxframe_boundary%0d got oLAST=%b required 1", i, oLAST);
        end
      end
    end
    tests_run++;
    if (n_beats != 22 || n_lasts != 3 || TRIG_CNT !== 16'd3) begin
      tests_failed++;
      $display("FAIL maxframe_totals got beats=%0d lasts=%0d cnt=%0d required 22 3 3",
               n_beats, n_lasts, TRIG_CNT);
    end
  endtask

  task automatic test_valid_gaps();
    apply_reset();
    THRESHOLD = -16'sd100; POST_ACQ = 5'd2;
    for (int i = 0; i < 12; i++) begin
      step((i % 2) == 0, (i == 0) ? make_beat(5, -300) : make_beat(-1, 0), rand_payload());
      tests_run++;
      if ({oVALID, oLAST, TRIG_CNT, DOUT} !== {m_valid, m_last, m_trig, m_dout}) begin
        tests_failed++;
        $display("FAIL gaps_cycle%0d got v=%b l=%b cnt=%0d required v=%b l=%b cnt=%0d",
                 i, oVALID, oLAST, TRIG_CNT, m_valid, m_last, m_trig);
      end
    end
    tests_run++;
    if (n_beats != 4 || n_lasts != 1 || TRIG_CNT !== 16'd1) begin
      tests_failed++;
      $display("FAIL gaps_totals got beats=%0d lasts=%0d cnt=%0d required 4 1 1",
               n_beats, n_lasts, TRIG_CNT);
    end
  endtask

  task automatic test_equal_threshold();
    apply_reset();
    THRESHOLD = -16'sd100; POST_ACQ = 5'd0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, make_beat(i, -100), rand_payload());
      tests_run++;
      if (oVALID !== 1'b0 || TRIG_CNT !== 16'd0) begin
        tests_failed++;
        $display("FAIL equal_nohit%0d got v=%b cnt=%0d required v=0 cnt=0", i, oVALID, TRIG_CNT);
      end
    end
    step(1'b1, make_beat(7, -101), rand_payload());
    step(1'b1, make_beat(-1, 0), rand_payload());
    tests_run++;
    if (oVALID !== 1'b1 || oLAST !== 1'b1 || TRIG_CNT !== 16'd1) begin
      tests_failed++;
      $display("FAIL below_by_one got v=%b l=%b cnt=%0d required 1 1 1", oVALID, oLAST, TRIG_CNT);
    end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    THRESHOLD = -16'sd100; POST_ACQ = 5'd4;
    step(1'b1, make_beat(2, -200), rand_payload());
    step(1'b1, make_beat(-1, 0), rand_payload());
    THRESHOLD = 16'sd0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, make_beat(1, -50), rand_payload());
      tests_run++;
      if ({oVALID, oLAST, TRIG_CNT, DOUT} !== {m_valid, m_last, m_trig, m_dout}) begin
        tests_failed++;
        $display("FAIL midframe_latched%0d got v=%b l=%b cnt=%0d required v=%b l=%b cnt=%0d",
                 i, oVALID, oLAST, TRIG_CNT, m_valid, m_last, m_trig);
      end
    end
    #2 RESETN = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if ({oVALID, oLAST, TRIG_CNT} !== {1'b0, 1'b0, 16'h0}) begin
      tests_failed++;
      $display("FAIL async_abort got v=%b l=%b cnt=%0d required 0 0 0", oVALID, oLAST, TRIG_CNT);
    end
    #1 RESETN = 1'b1;
    step(1'b1, make_beat(1, -50), rand_payload());
    tests_run++;
    if (oVALID !== 1'b1 || TRIG_CNT !== 16'd1) begin
      tests_failed++;
      $display("FAIL new_threshold got v=%b cnt=%0d required v=1 cnt=1", oVALID, TRIG_CNT);
    end
  endtask

  task automatic test_random();
    logic signed [SW-1:0] thr_set [5];
    int lane;
    thr_set = '{-16'sd100, -16'sd50, 16'sd0, -16'sd150, -16'sd1};
    apply_reset();
    THRESHOLD = -16'sd100; POST_ACQ = 5'd2;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) < 2) THRESHOLD = thr_set[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) POST_ACQ = PW'($urandom_range(0, 5));
      lane = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, LANES - 1)) : -1;
      step($urandom_range(0, 9) < 8, make_beat(lane, -int'($urandom_range(1, 200))), rand_payload());
      tests_run++;
      if ({oVALID, oLAST, TRIG_CNT, DOUT} !== {m_valid, m_last, m_trig, m_dout}) begin
        tests_failed++;
        $display("FAIL random_cycle%0d got v=%b l=%b cnt=%0d dout=%h required v=%b l=%b cnt=%0d dout=%h",
                 i, oVALID, oLAST, TRIG_CNT, DOUT, m_valid, m_last, m_trig, m_dout);
      end
    end
  endtask

  initial begin
    THRESHOLD = -16'sd100; POST_ACQ = 5'd2; iVALID = 1'b0;
    TRIG_DIN = '0; DELAYED_DIN = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    test_reset();
    test_single_hit();
    test_retrigger();
    test_max_frame();
    test_valid_gaps();
    test_equal_threshold();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
